// File: rtl/spike_rr_analyzer.sv
// spike_rr_analyzer
//   Turns the neuron spike train into heartbeat timing. Every accepted rising
//   edge of `spike` is one R-peak. The block measures the RR interval in clock
//   cycles and keeps a running average over the last 8 intervals. It also
//   flags irregular beats and asystole (no beat within MAX_RR cycles).
//
// Ports
//   CLK        in   system clock, rising edge
//   KEY        in   asynchronous active-high reset
//   spike      in   neuron spike level (may stay high for several cycles)
//   rr_out     out  last measured RR interval
//   rr_valid   out  one-cycle pulse when rr_out updates
//   rr_avg     out  (sum of the last 8 RR values) >> 3
//   avg_valid  out  8 RR values collected since reset/asystole
//   irregular  out  new RR deviates from the previous average (valid with rr_valid)
//   asystole   out  sticky timeout flag, cleared by the next beat
//   beat_cnt   out  accepted beats, wraps silently
module spike_rr_analyzer #(
  parameter int CNT_W     = 20,
  parameter int REFRACT   = 4,
  parameter int MAX_RR    = 100,
  parameter int IRR_SHIFT = 3
) (
  input  logic             CLK,
  input  logic             KEY,
  input  logic             spike,
  output logic [CNT_W-1:0] rr_out,
  output logic             rr_valid,
  output logic [CNT_W-1:0] rr_avg,
  output logic             avg_valid,
  output logic             irregular,
  output logic             asystole,
  output logic [15:0]      beat_cnt
);

  typedef enum logic {
    IDLE,   // no reference beat yet
    COUNT   // measuring the interval since the last beat
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] REFRACT_C = CNT_W'(REFRACT);
  localparam logic [CNT_W-1:0] MAX_RR_C  = CNT_W'(MAX_RR);
  localparam int               SUM_W     = CNT_W + 3;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               spike_q;
  logic [CNT_W-1:0]   hist_q [8];
  logic [CNT_W-1:0]   hist_d [8];
  logic [3:0]         hist_n_q, hist_n_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   rr_out_q, rr_out_d;
  logic               rr_valid_q, rr_valid_d;
  logic [CNT_W-1:0]   rr_avg_q, rr_avg_d;
  logic               avg_valid_q, avg_valid_d;
  logic               irregular_q, irregular_d;
  logic               asystole_q, asystole_d;
  logic [15:0]        beat_cnt_q, beat_cnt_d;

  logic               rise;
  logic               accept;
  logic               timeout;
  logic [SUM_W-1:0]   sum_next;
  logic [CNT_W-1:0]   dev;
  logic [CNT_W-1:0]   dev_thr;

  // A level held high produces exactly one rise.
  assign rise = spike & ~spike_q;

  // A beat arriving on the timeout edge takes priority over the timeout.
  assign accept  = (state_q == COUNT) && rise && (cnt_q >= REFRACT_C);
  assign timeout = (state_q == COUNT) && !accept && (cnt_q == MAX_RR_C);

  // Evicted history slots are zero until the window fills, so the running
  // sum is correct from the very first interval.
  assign sum_next = sum_q + {3'b000, cnt_q} - {3'b000, hist_q[7]};

  // Unsigned absolute difference against the previous average.
  assign dev     = (cnt_q >= rr_avg_q) ? (cnt_q - rr_avg_q) : (rr_avg_q - cnt_q);
  assign dev_thr = rr_avg_q >> IRR_SHIFT;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which is what keeps this block from inferring latches.
    state_d     = state_q;
    cnt_d       = cnt_q;
    hist_d      = hist_q;
    hist_n_d    = hist_n_q;
    sum_d       = sum_q;
    rr_out_d    = rr_out_q;
    rr_valid_d  = 1'b0;
    rr_avg_d    = rr_avg_q;
    avg_valid_d = avg_valid_q;
    irregular_d = irregular_q;
    asystole_d  = asystole_q;
    beat_cnt_d  = beat_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d    = COUNT;
          cnt_d      = CNT_ONE;
          beat_cnt_d = beat_cnt_q + 16'd1;
          asystole_d = 1'b0;
        end
      end

      COUNT: begin
        if (accept) begin
          rr_out_d   = cnt_q;
          rr_valid_d = 1'b1;
          cnt_d      = CNT_ONE;
          beat_cnt_d = beat_cnt_q + 16'd1;

          hist_d[0] = cnt_q;
          for (int i = 1; i < 8; i++) begin
            hist_d[i] = hist_q[i-1];
          end
          hist_n_d = (hist_n_q == 4'd8) ? 4'd8 : hist_n_q + 4'd1;
          sum_d    = sum_next;
          rr_avg_d = sum_next[SUM_W-1:3];
          if (hist_n_d == 4'd8) begin
            avg_valid_d = 1'b1;
          end

          // Judged against the average as it stood before this beat.
          irregular_d = avg_valid_q && (dev > dev_thr);
        end else if (timeout) begin
          state_d     = IDLE;
          cnt_d       = '0;
          asystole_d  = 1'b1;
          hist_d      = '{default: '0};
          hist_n_d    = 4'd0;
          sum_d       = '0;
          rr_avg_d    = '0;
          avg_valid_d = 1'b0;
        end else if (cnt_q != MAX_RR_C) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge KEY) begin
    if (KEY) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      spike_q     <= 1'b0;
      // NOTE: the history window is reset explicitly; the running sum
      // subtracts the oldest slot, so stale contents would corrupt rr_avg.
      hist_q      <= '{default: '0};
      hist_n_q    <= 4'd0;
      sum_q       <= '0;
      rr_out_q    <= '0;
      rr_valid_q  <= 1'b0;
      rr_avg_q    <= '0;
      avg_valid_q <= 1'b0;
      irregular_q <= 1'b0;
      asystole_q  <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, regardless of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      spike_q     <= spike;
      hist_q      <= hist_d;
      hist_n_q    <= hist_n_d;
      sum_q       <= sum_d;
      rr_out_q    <= rr_out_d;
      rr_valid_q  <= rr_valid_d;
      rr_avg_q    <= rr_avg_d;
      avg_valid_q <= avg_valid_d;
      irregular_q <= irregular_d;
      asystole_q  <= asystole_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign rr_out    = rr_out_q;
  assign rr_valid  = rr_valid_q;
  assign rr_avg    = rr_avg_q;
  assign avg_valid = avg_valid_q;
  assign irregular = irregular_q;
  assign asystole  = asystole_q;
  assign beat_cnt  = beat_cnt_q;

endmodule
